// File: rtl/cam_ctrl_if.sv
// cam_ctrl_if: valid/ready request and response bundle for cam_ctrl.
// master = requester side, slave = controller side.
interface cam_ctrl_if #(
  parameter int CAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [CAM_WIDTH-1:0]  req_data;
  logic [CAM_WIDTH-1:0]  req_mask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic                  resp_multi;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  resp_err;

  modport master (
    output req_valid, req_op, req_addr,
    output req_data, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_hit,
    input  resp_multi, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    input  req_data, req_mask, resp_ready,
    output req_ready, resp_valid, resp_hit,
    output resp_multi, resp_addr, resp_err
  );
endinterface

// File: rtl/cam_ctrl.sv
// cam_ctrl: sequences a CAM array for one requester (write / search).
// Ports: clk, rst (sync, active-low), bus (cam_ctrl_if.slave:
//   req_* in, resp_* out), cam_we_decoded_row_address,
//   cam_search_word, cam_dont_care_mask (to CAM),
//   cam_decoded_match_address (from CAM).
// Option: define CAM_CTRL_VALID_BITS_EN to gate matches with
//   per-row valid bits set by successful writes.
module cam_ctrl #(
  parameter int CAM_WIDTH  = 8,
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_ctrl_if.slave            bus,
  output logic [CAM_DEPTH-1:0] cam_we_decoded_row_address,
  output logic [CAM_WIDTH-1:0] cam_search_word,
  output logic [CAM_WIDTH-1:0] cam_dont_care_mask,
  input  logic [CAM_DEPTH-1:0] cam_decoded_match_address
);

  typedef enum logic [2:0] {
    IDLE, WR, SRCH, CAPT, RESP
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_hit;
  logic                  r_multi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic [CAM_DEPTH-1:0]  r_we;
  logic [CAM_WIDTH-1:0]  r_word;
  logic [CAM_WIDTH-1:0]  r_mask;

  logic [CAM_DEPTH-1:0]  w_match;
  logic [CAM_DEPTH-1:0]  w_onehot;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_wr_ok;
  logic                  w_multi;

`ifdef CAM_CTRL_VALID_BITS_EN
  logic [CAM_DEPTH-1:0]  r_valid;
  assign w_match = cam_decoded_match_address & r_valid;
`else
  assign w_match = cam_decoded_match_address;
`endif

  assign w_wr_ok  = int'(bus.req_addr) < CAM_DEPTH;
  assign w_onehot = CAM_DEPTH'(1) << bus.req_addr;
  // Clearing the lowest set bit leaves something iff >1 bit set.
  assign w_multi  = |(w_match & (w_match - CAM_DEPTH'(1)));

  // Scan high to low so row 0 wins.
  always_comb begin
    w_addr = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) w_addr = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_multi      <= 1'b0;
      r_addr       <= '0;
      r_err        <= 1'b0;
      r_we         <= '0;
      r_word       <= '0;
      r_mask       <= '0;
`ifdef CAM_CTRL_VALID_BITS_EN
      r_valid      <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_word      <= bus.req_data;
            if (bus.req_op) begin
              r_mask  <= '0;
              // Row enable is registered so it is high only in WR.
              r_we    <= w_wr_ok ? w_onehot : '0;
              r_state <= WR;
            end else begin
              r_mask  <= bus.req_mask;
              r_state <= SRCH;
            end
          end
        end
        WR: begin
`ifdef CAM_CTRL_VALID_BITS_EN
          r_valid      <= r_valid | r_we;
`endif
          r_err        <= ~|r_we;
          r_we         <= '0;
          r_hit        <= 1'b0;
          r_multi      <= 1'b0;
          r_addr       <= '0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        SRCH: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_hit        <= |w_match;
          r_multi      <= w_multi;
          r_addr       <= w_addr;
          r_err        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_we        <= '0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready              = r_req_ready;
  assign bus.resp_valid             = r_resp_valid;
  assign bus.resp_hit               = r_hit;
  assign bus.resp_multi             = r_multi;
  assign bus.resp_addr              = r_addr;
  assign bus.resp_err               = r_err;
  assign cam_we_decoded_row_address = r_we;
  assign cam_search_word            = r_word;
  assign cam_dont_care_mask         = r_mask;

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed + random write/search traffic for cam_ctrl
// against a CAM array stand-in and a row-table reference model.
module tb_cam_ctrl;
  localparam int CW = 8;
  localparam int CD = 8;
  localparam int AW = 4;
`ifdef CAM_CTRL_VALID_BITS_EN
  localparam bit VB = 1'b1;
`else
  localparam bit VB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CD-1:0] we;
  logic [CD-1:0] match;
  logic [CW-1:0] word;
  logic [CW-1:0] dmask;

  cam_ctrl_if #(.CAM_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

  cam_ctrl #(
    .CAM_WIDTH (CW),
    .CAM_DEPTH (CD),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .bus                       (bus),
    .cam_we_decoded_row_address(we),
    .cam_search_word           (word),
    .cam_dont_care_mask        (dmask),
    .cam_decoded_match_address (match)
  );

  always #5 clk = ~clk;

  // CAM array stand-in: rows cleared on reset, written on enable.
  logic [CW-1:0] cam_mem [CD];
  always @(posedge clk) begin
    for (int r = 0; r < CD; r++) begin
      if (!rst) cam_mem[r] <= '0;
      else if (we[r]) cam_mem[r] <= word;
    end
  end
  always_comb begin
    match = '0;
    for (int r = 0; r < CD; r++)
      match[r] = (((cam_mem[r] ^ word) & ~dmask) == '0);
  end

  // Reference: contents and written-since-reset flag per row.
  logic [CW-1:0] ref_mem [CD];
  bit            ref_v   [CD];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int r = 0; r < CD; r++) begin
      ref_mem[r] = '0;
      ref_v[r]   = 1'b0;
    end
  endtask

  function automatic logic [CW-1:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 8'hA5;
      1: return 8'hA4;
      2: return 8'h5A;
      3: return 8'h00;
      default: return CW'($urandom);
    endcase
  endfunction

  task automatic do_req(input bit op,
                        input logic [AW-1:0] a,
                        input logic [CW-1:0] d,
                        input logic [CW-1:0] m,
                        input int hold,
                        input bit poke);
    int            lat;
    int            wecnt;
    int            cnt;
    logic [CD-1:0] weseen;
    logic [CD-1:0] ewe;
    bit            ehit, emulti, eerr;
    logic [AW-1:0] eaddr;
    logic [31:0]   snap;
    ehit = 0; emulti = 0; eerr = 0; eaddr = '0; ewe = '0;
    if (op) begin
      eerr = (int'(a) >= CD);
      if (!eerr) ewe[a] = 1'b1;
    end else begin
      cnt = 0;
      for (int r = 0; r < CD; r++) begin
        if ((!VB || ref_v[r]) &&
            (((ref_mem[r] ^ d) & ~m) == '0)) begin
          if (cnt == 0) eaddr = AW'(r);
          cnt++;
        end
      end
      ehit   = cnt > 0;
      emulti = cnt > 1;
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_mask  = m;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; wecnt = 0; weseen = '0;
    while (!bus.resp_valid && lat < 10) begin
      if (we != '0) begin
        wecnt++;
        weseen = we;
      end
      chk("req_ready_busy", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, op ? 2 : 3);
    chk("hit", 32'(bus.resp_hit), 32'(ehit));
    chk("multi", 32'(bus.resp_multi), 32'(emulti));
    chk("addr", 32'(bus.resp_addr), 32'(eaddr));
    chk("err", 32'(bus.resp_err), 32'(eerr));
    chk("we_cycles", wecnt, (ewe != '0) ? 1 : 0);
    chk("we_value", 32'(weseen), 32'(ewe));
    chk("word", 32'(word), 32'(d));
    chk("mask", 32'(dmask), op ? 0 : 32'(m));

    snap = {bus.resp_hit, bus.resp_multi, bus.resp_addr,
            bus.resp_err, bus.req_ready, bus.resp_valid,
            we, word};
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_addr  = AW'($urandom_range(0, CD - 1));
        bus.req_data  = CW'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_stable",
          {bus.resp_hit, bus.resp_multi, bus.resp_addr,
           bus.resp_err, bus.req_ready, bus.resp_valid,
           we, word}, snap);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid_drop", 32'(bus.resp_valid), 0);
    chk("req_ready_back", 32'(bus.req_ready), 1);
    if (op && !eerr) begin
      ref_mem[a] = d;
      ref_v[a]   = 1'b1;
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_mask   = '0;
    bus.resp_ready = 1'b0;
    ref_clear();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp", {bus.resp_valid, bus.resp_hit,
        bus.resp_multi, bus.resp_err, 28'(bus.resp_addr)}, 0);
    chk("rst_cam", {we, word, dmask}, 0);
    rst = 1'b1;

    do_req(1'b1, 4'd3, 8'hA5, 8'h00, 0, 0);
    do_req(1'b0, 4'd0, 8'hA5, 8'h00, 0, 0);
    do_req(1'b1, 4'd1, 8'hA4, 8'h00, 0, 0);
    do_req(1'b0, 4'd0, 8'hA5, 8'h01, 0, 0);
    do_req(1'b1, 4'd8, 8'h5A, 8'h00, 0, 0);
    do_req(1'b0, 4'd0, 8'hA5, 8'h01, 0, 0);
    do_req(1'b1, 4'd15, 8'h00, 8'h00, 2, 0);
    do_req(1'b0, 4'd0, 8'hA5, 8'h01, 5, 1);
    do_req(1'b1, 4'd7, 8'hA5, 8'h00, 0, 0);
    do_req(1'b0, 4'd0, 8'h25, 8'h80, 0, 0);

    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 9)),
             pick_data(),
             ($urandom_range(0, 1) == 0) ? 8'h00 : CW'($urandom),
             $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    // Reset while a search sits in SRCH.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_data  = 8'hA5;
    bus.req_mask  = 8'h00;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_resp", {bus.resp_valid, bus.resp_hit,
        bus.resp_multi, bus.resp_err, 28'(bus.resp_addr)}, 0);
    chk("mid_rst_cam", {we, word, dmask}, 0);
    rst = 1'b1;
    ref_clear();
    do_req(1'b0, 4'd0, 8'h00, 8'h00, 0, 0);
    do_req(1'b1, 4'd5, 8'h00, 8'h00, 0, 0);
    do_req(1'b0, 4'd0, 8'h00, 8'h00, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Request/response controller that sequences a CAM_Array instance (CAM_DEPTH rows × CAM_WIDTH bits) for a single requester.
- Accepts one write or search per transaction over a valid/ready handshake.
- Writes: drives the one-hot row write-enable.
- Searches: drives search word and don't-care mask, captures the decoded match vector, and returns a priority-encoded hit address, hit and multi-hit flags.

Parameters:
- CAM_WIDTH, 8, bits per CAM word.
- CAM_DEPTH, 8, number of CAM rows.
- ADDR_WIDTH, 3, row address width; must satisfy 2**ADDR_WIDTH >= CAM_DEPTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  1  0 = search, 1 = write.
- req_addr  input  ADDR_WIDTH  write row address; ignored for search.
- req_data  input  CAM_WIDTH  write data or search key.
- req_mask  input  CAM_WIDTH  search don't-care mask (1 = ignore bit); ignored for write.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_hit  output  1  search found at least one matching row.
- resp_multi  output  1  search matched more than one row.
- resp_addr  output  ADDR_WIDTH  lowest-index matching row; 0 when no hit.
- resp_err  output  1  write address out of range.
- cam_we_decoded_row_address  output  CAM_DEPTH  one-hot row write enable to CAM.
- cam_search_word  output  CAM_WIDTH  write data / search key to CAM.
- cam_dont_care_mask  output  CAM_WIDTH  search mask to CAM.
- cam_decoded_match_address  input  CAM_DEPTH  per-row match vector from CAM.

Behaviour:
- Reset (rst == 0 at a clock edge): state IDLE.
  - req_ready = 1; resp_valid = resp_hit = resp_multi = resp_err = 0; resp_addr = 0.
  - All cam_* outputs = 0.
  - Reset mid-transaction aborts it. No partial write survives: we is forced to 0 in the same edge.
- States: IDLE, WR, SRCH, CAPT, RESP.
- All outputs are registered. req_ready = 1 only in IDLE.
- IDLE:
  - On req_valid & req_ready, latch op/addr/data/mask.
  - Write → WR. Search → SRCH.
  - cam_search_word ← req_data in both cases.
  - cam_dont_care_mask ← req_mask for search, all-zeros for write.
- WR (exactly one cycle):
  - If addr < CAM_DEPTH: cam_we_decoded_row_address = one-hot(addr), resp_err = 0.
  - Else: we stays all-zero and resp_err = 1.
  - Next state RESP; resp_hit = resp_multi = 0, resp_addr = 0.
  - Response is valid 2 cycles after the accept edge.
- SRCH (one cycle):
  - CAM inputs are held stable; no write-enable is driven.
  - Next state CAPT.
- CAPT:
  - Sample cam_decoded_match_address at this edge into match_q.
  - resp_hit = |match_q.
  - resp_multi = more than one bit set.
  - resp_addr = lowest set index (row 0 highest priority).
  - resp_err = 0. Next state RESP.
  - Response is valid 3 cycles after the accept edge.
- RESP:
  - resp_valid = 1; all response fields held stable until resp_valid & resp_ready.
  - On handshake: resp_valid ← 0, next state IDLE, req_ready ← 1 on the following cycle.
  - No back-to-back overlap: a new request is accepted no earlier than 1 cycle after the response handshake.
- cam_search_word and cam_dont_care_mask hold their last driven values outside a transaction.
- cam_we_decoded_row_address is all-zero in every state except WR.
- Match vector with all bits set: resp_addr = 0, resp_multi = 1.
- Unused encodings of resp_addr (CAM_DEPTH < 2**ADDR_WIDTH) never appear on a search hit.

Optional Feature:
- Macro: CAM_CTRL_VALID_BITS_EN.
- Defined:
  - Controller keeps a CAM_DEPTH-bit valid register, cleared on reset.
  - Each successful WR sets the valid bit of the written row.
  - In CAPT, match_q = cam_decoded_match_address & valid before hit/multi/addr are computed.
  - Effect: rows never written since reset never report a hit.
- Undefined:
  - No valid register; the raw match vector is used.
  - Reset-zeroed CAM rows match a key of 0.

Test Plan:
- Reset, then write 0xA5 to row 3 → we = 0x08 for exactly 1 cycle in WR; resp_valid 2 cycles after accept; resp_err = 0, resp_hit = 0.
- After the above, search key 0xA5, mask 0x00 → resp_valid 3 cycles after accept; hit = 1, addr = 3, multi = 0.
- Write 0xA4 to row 1, then search 0xA5 with mask 0x01 → hit = 1, multi = 1, addr = 1 (rows 1 and 3 match).
- Write with req_addr = 8 on an 8-row CAM with ADDR_WIDTH = 4 → we stays 0x00 throughout; resp_err = 1; a following search shows no change.
- Hold resp_ready = 0 for 5 cycles in RESP → resp_valid and all fields stable; req_ready = 0; a req_valid pulse is ignored; release → IDLE next cycle.
- Deassert rst during SRCH → next cycle all outputs zero and req_ready = 1. With CAM_CTRL_VALID_BITS_EN, a search for 0x00 after reset → hit = 0; without the macro → hit = 1, addr = 0, multi = 1.
